// File: rtl/oai_nm_pipe.sv
// Lane-parallel OAI/AOI evaluator behind an elastic valid/ready register pipeline.
// Latency STAGES cycles, 1 beat/cycle; a full pipeline deasserts in_ready combinationally from out_ready.
module oai_nm_pipe #(
  parameter int GROUPS  = 3,
  parameter int GROUP_W = 2,
  parameter int LANES   = 1,
  parameter int STAGES  = 2
) (
  input  logic                              CLK,
  input  logic                              RN,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_mode,
  input  logic [LANES*GROUPS*GROUP_W-1:0]   in_a,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES-1:0]                  out_zn,
  output logic                              out_mode
);

  localparam int TW = LANES * GROUPS;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] mode_q;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] vld_prev;
  logic [STAGES-1:0] mode_prev;
  logic [TW-1:0]     term_d;

  // Final inversion: NAND of OR terms (OAI) or NOR of AND terms (AOI).
  function automatic logic [LANES-1:0] reduce_terms(input logic [TW-1:0] t, input logic m);
    logic [LANES-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      r[l] = m ? ~(|t[l*GROUPS +: GROUPS]) : ~(&t[l*GROUPS +: GROUPS]);
    end
    return r;
  endfunction

  always_comb begin
    term_d = '0;
    for (int j = 0; j < TW; j++) begin
      term_d[j] = in_mode ? (&in_a[j*GROUP_W +: GROUP_W]) : (|in_a[j*GROUP_W +: GROUP_W]);
    end
  end

  // A stage is ready if it or any stage downstream of it has a free slot.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < STAGES; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!vld_q[j]) rdy[k] = 1'b1;
      end
    end
  end

  assign vld_prev  = STAGES'({vld_q, in_valid});
  assign mode_prev = STAGES'({mode_q, in_mode});
  assign load      = rdy & vld_prev;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      vld_q  <= '0;
      mode_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k])  vld_q[k]  <= vld_prev[k];
        if (load[k]) mode_q[k] <= mode_prev[k];
      end
    end
  end

  // Data only moves with a valid beat, so out_zn holds across bubbles.
  if (STAGES == 1) begin : g_one
    logic [LANES-1:0] zn_q;

    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
        zn_q <= '0;
      end else if (load[0]) begin
        zn_q <= reduce_terms(term_d, in_mode);
      end
    end

    assign out_zn = zn_q;
  end else begin : g_multi
    logic [TW-1:0]    term_q;
    logic [LANES-1:0] zn_q [STAGES-1];  // entry s belongs to stage s+2

    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
        term_q <= '0;
        for (int s = 0; s < STAGES-1; s++) zn_q[s] <= '0;
      end else begin
        if (load[0]) term_q  <= term_d;
        if (load[1]) zn_q[0] <= reduce_terms(term_q, mode_q[0]);
        for (int s = 1; s < STAGES-1; s++) begin
          if (load[s+1]) zn_q[s] <= zn_q[s-1];
        end
      end
    end

    assign out_zn = zn_q[STAGES-2];
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];

endmodule

// File: tb/tb_oai_nm_pipe.sv
// Bench for oai_nm_pipe: directed vector table, stall/reset sequences and random scoreboard runs.
module tb_oai_nm_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: OAI is low only when every group has a set bit; AOI is low when any group is all ones.
  function automatic logic [31:0] model(input logic [63:0] a, input logic m,
                                        input int lanes, input int groups, input int gw);
    logic [31:0] z;
    int nonempty, full, ones;
    z = '0;
    for (int l = 0; l < lanes; l++) begin
      nonempty = 0;
      full = 0;
      for (int g = 0; g < groups; g++) begin
        ones = 0;
        for (int i = 0; i < gw; i++) ones += int'(a[(l*groups + g)*gw + i]);
        if (ones > 0)  nonempty++;
        if (ones == gw) full++;
      end
      z[l] = m ? (full == 0) : (nonempty != groups);
    end
    return z;
  endfunction

  // ---------------- default-parameter DUT ----------------
  logic       rn, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [5:0] in_a;
  logic [0:0] out_zn;

  oai_nm_pipe u_dut (
    .CLK(clk), .RN(rn),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_zn(out_zn), .out_mode(out_mode)
  );

  logic [1:0]  sbq[$];  // {mode, zn}
  logic [1:0]  sbe;
  logic [31:0] mz;
  bit          sb_en = 1'b0;
  int          pop_cnt = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got out_zn=%0b with no beat outstanding", out_zn);
        end else begin
          sbe = sbq.pop_front();
          check("sb_zn", 64'(out_zn), 64'(sbe[0]));
          check("sb_mode", 64'(out_mode), 64'(sbe[1]));
          pop_cnt++;
        end
      end else if (out_valid && sbq.size() > 0) begin
        sbe = sbq[0];
        check("stall_zn", 64'(out_zn), 64'(sbe[0]));
        check("stall_mode", 64'(out_mode), 64'(sbe[1]));
      end
      if (in_valid && in_ready) begin
        mz = model(64'(in_a), in_mode, 1, 3, 2);
        sbq.push_back({in_mode, mz[0]});
      end
    end
  end

  // ---------------- parametric sweep: LANES=4, GROUPS=4, GROUP_W=3, STAGES 1 and 4 ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_sw
    localparam int STG = (gi == 0) ? 1 : 4;
    localparam int NB  = 48;
    logic          rn_s, iv, ir, im, ov, ordy, om;
    logic [NB-1:0] ia;
    logic [3:0]    oz;
    bit            done_s = 1'b0;

    oai_nm_pipe #(.GROUPS(4), .GROUP_W(3), .LANES(4), .STAGES(STG)) u_sw (
      .CLK(clk), .RN(rn_s),
      .in_valid(iv), .in_ready(ir), .in_mode(im), .in_a(ia),
      .out_valid(ov), .out_ready(ordy), .out_zn(oz), .out_mode(om)
    );

    initial begin
      logic [4:0]  q[$];
      logic [4:0]  e;
      logic [31:0] z;
      logic [63:0] r;
      int          acc, cyc, lat;
      bit          feed;
      rn_s = 1'b0; iv = 1'b0; im = 1'b0; ia = '0; ordy = 1'b1;
      repeat (3) @(posedge clk);
      #1 rn_s = 1'b1;
      acc = 0;
      for (cyc = 0; cyc < 20000; cyc++) begin
        @(posedge clk);
        #1;
        feed = (acc < 1000);
        if (!feed && q.size() == 0 && !ov) break;
        r    = {$urandom, $urandom};
        ia   = r[NB-1:0];
        im   = 1'($urandom_range(0, 1));
        iv   = feed && ($urandom_range(0, 3) != 0);
        ordy = !feed || ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (ov && ordy) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sw%0d_unexpected_beat: got out_zn=%0h with no beat outstanding", STG, oz);
          end else begin
            e = q.pop_front();
            check($sformatf("sw%0d_zn", STG), 64'(oz), 64'(e[3:0]));
            check($sformatf("sw%0d_mode", STG), 64'(om), 64'(e[4]));
          end
        end else if (ov && q.size() > 0) begin
          e = q[0];
          check($sformatf("sw%0d_stall_zn", STG), 64'(oz), 64'(e[3:0]));
        end
        if (iv && ir) begin
          z = model(64'(ia), im, 4, 4, 3);
          q.push_back({im, z[3:0]});
          acc++;
        end
      end
      check($sformatf("sw%0d_accepted", STG), 64'(acc), 64'd1000);
      check($sformatf("sw%0d_drained", STG), 64'(q.size()), 64'd0);

      // Single beat into an empty pipeline with out_ready high.
      @(posedge clk);
      #1;
      r = {$urandom, $urandom};
      ia = r[NB-1:0];
      im = 1'($urandom_range(0, 1));
      iv = 1'b1;
      ordy = 1'b1;
      z = model(64'(ia), im, 4, 4, 3);
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        iv = 1'b0;
        lat++;
      end while (!ov && lat < 20);
      check($sformatf("sw%0d_latency", STG), 64'(lat), 64'(STG));
      check($sformatf("sw%0d_lat_zn", STG), 64'(oz), 64'(z[3:0]));
      check($sformatf("sw%0d_lat_mode", STG), 64'(om), 64'(im));
      done_s = 1'b1;
    end
  end

  // ---------------- directed tests on the default DUT ----------------
  typedef struct {
    logic [5:0] a;
    logic       m;
    logic       zn;
  } vec_t;

  vec_t tv[8];

  initial begin
    int lat, base, sent, seen, cnt;
    tv[0] = '{a: 6'b000000, m: 1'b0, zn: 1'b1};
    tv[1] = '{a: 6'b010101, m: 1'b0, zn: 1'b0};
    tv[2] = '{a: 6'b110001, m: 1'b0, zn: 1'b1};
    tv[3] = '{a: 6'b000011, m: 1'b1, zn: 1'b0};
    tv[4] = '{a: 6'b100101, m: 1'b1, zn: 1'b1};
    tv[5] = '{a: 6'b111111, m: 1'b0, zn: 1'b0};
    tv[6] = '{a: 6'b111111, m: 1'b1, zn: 1'b0};
    tv[7] = '{a: 6'b000000, m: 1'b1, zn: 1'b1};

    rn = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_a = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_zn", 64'(out_zn), 64'd0);
    check("rst_out_mode", 64'(out_mode), 64'd0);
    repeat (3) @(posedge clk);
    #1 rn = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    sb_en = 1'b1;

    // Vector table, one beat at a time.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; in_a = tv[k].a; in_mode = tv[k].m;
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat++;
      end while (!out_valid && lat < 10);
      check($sformatf("tv%0d_latency", k), 64'(lat), 64'd2);
      check($sformatf("tv%0d_zn", k), 64'(out_zn), 64'(tv[k].zn));
      check($sformatf("tv%0d_mode", k), 64'(out_mode), 64'(tv[k].m));
    end
    @(posedge clk);

    // Back-to-back beats with alternating mode.
    base = pop_cnt;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; in_mode = k[0]; in_a = 6'($urandom);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("alt_count", 64'(pop_cnt - base), 64'd4);

    // 8-beat stream, out_ready low for cycles 3..6.
    base = pop_cnt;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      in_a      = 6'(sent * 7 + 3);
      in_mode   = sent[0];
      @(negedge clk);
      if (c >= 3 && c <= 6) check($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'd0);
      if (c == 7) check("bp_in_ready_resume", 64'(in_ready), 64'd1);
      if (in_valid && in_ready) sent++;
    end
    check("bp_count", 64'(pop_cnt - base), 64'd8);

    // Reset with two beats held in the pipeline.
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b1; in_a = 6'b000000; in_mode = 1'b1;
    @(posedge clk);
    #1;
    in_a = 6'b000000; in_mode = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mr_full_before", 64'(out_valid), 64'd1);
    check("mr_full_in_ready", 64'(in_ready), 64'd0);
    sb_en = 1'b0;
    rn = 1'b0;
    #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_out_zn", 64'(out_zn), 64'd0);
    check("mr_out_mode", 64'(out_mode), 64'd0);
    #4 rn = 1'b1;
    sbq.delete();
    sb_en = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("mr_no_stale", 64'(seen), 64'd0);
    base = pop_cnt;
    in_valid = 1'b1; in_a = 6'b010101; in_mode = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("mr_new_beat", 64'(pop_cnt - base), 64'd1);

    // Exhaustive: all operands, both modes, streamed.
    base = pop_cnt;
    for (int v = 0; v < 128; v++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; in_a = 6'(v); in_mode = v[6];
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("exh_count", 64'(pop_cnt - base), 64'd128);

    // Random valid/ready traffic.
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_mode   = 1'($urandom_range(0, 1));
      in_a      = 6'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("rnd_drained", 64'(sbq.size()), 64'd0);

    cnt = 0;
    while (!(g_sw[0].done_s && g_sw[1].done_s) && cnt < 40000) begin
      @(posedge clk);
      cnt++;
    end
    check("sweeps_done", 64'(g_sw[0].done_s && g_sw[1].done_s), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
